alu16_seq_unit: RTL and testbench



---
 rtl/alu16_pkg.sv | 25 ++
 rtl/alu16_muldiv_step.sv | 54 +++++
 rtl/alu16_seq_unit.sv | 155 +++++++++++++++
 tb/tb_alu16_seq_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// alu16_pkg
// Shared constants for the sequential 16-bit ALU:
//   - opcode encodings presented on the sel input
//   - FSM state encodings (plain localparams for legacy tool compatibility)
//   - iteration counter width for the multi-cycle multiply/divide
package alu16_pkg;

  localparam int ALU_WIDTH = 16;

  // Opcodes driven on sel
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One extra bit so the counter can represent WIDTH itself if ever needed
  localparam int ITER_CNT_W = $clog2(ALU_WIDTH) + 1;

endpackage

// File: rtl/alu16_muldiv_step.sv
// alu16_muldiv_step
// Purely combinational single iteration shared by multiply and divide.
// The pair {hi, lo} is a double-width working register:
//   multiply (is_div=0): hi = running partial product, lo = remaining
//                        multiplier bits shifting out / product low half
//                        shifting in. After WIDTH steps {hi,lo} = a*b.
//   divide   (is_div=1): hi = partial remainder, lo = dividend bits shifting
//                        out / quotient bits shifting in. After WIDTH steps
//                        lo = floor(a/b), hi = remainder.
// Ports:
//   is_div   in   select restoring-divide step instead of shift-add step
//   hi, lo   in   current working register halves
//   b        in   multiplicand / divisor
//   hi_next  out  next upper half
//   lo_next  out  next lower half
module alu16_muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    // The remainder always stays below b, so when the subtraction succeeds
    // the true difference fits in WIDTH bits and the low bits are exact.
    diff    = shifted[WIDTH-1:0] - b;

    // Shift-add: the carry of the addition becomes the new top bit and the
    // bit leaving the bottom of hi enters the top of lo.
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};

    if (is_div) begin
      if (shifted >= {1'b0, b}) begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu16_seq_unit.sv
// alu16_seq_unit
// Multi-cycle handshaked ALU. One operation is accepted on the input
// valid/ready channel, computed (ADD/SUB in one cycle, MUL/DIV iteratively
// over WIDTH cycles) and returned on the output valid/ready channel.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    operation presented;  in_ready  unit is idle and accepts
//   a, b, sel   operands and opcode, captured on the accept edge
//   out_valid   result available;     out_ready consumer takes the result
//   result, ov  result and overflow/error flag, held while out_valid
module alu16_seq_unit
  import alu16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ov
);

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic                  ov_q, ov_d;

  logic [WIDTH-1:0]      step_hi, step_lo;
  logic [WIDTH:0]        add_sum;
  logic [WIDTH-1:0]      sub_diff;

  alu16_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (state_q == ST_DIV),
    .hi      (hi_q),
    .lo      (lo_q),
    .b       (b_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Next-state logic. ADD, SUB and divide-by-zero finish on the accept edge;
  // MUL/DIV load the working register and iterate until the counter reaches
  // its last value. result/ov are only written on the way into DONE so they
  // keep their last value while idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    ov_d     = ov_q;

    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          b_d   = b;
          case (sel)
            ALU_ADD: begin
              result_d = add_sum[WIDTH-1:0];
              ov_d     = add_sum[WIDTH];
              state_d  = ST_DONE;
            end
            ALU_SUB: begin
              result_d = sub_diff;
              ov_d     = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (sub_diff[WIDTH-1] != a[WIDTH-1]);
              state_d  = ST_DONE;
            end
            ALU_MUL: begin
              hi_d    = '0;
              lo_d    = a;
              state_d = ST_MUL;
            end
            default: begin
              if (b == '0) begin
                result_d = '1;
                ov_d     = 1'b1;
                state_d  = ST_DONE;
              end else begin
                hi_d    = '0;
                lo_d    = a;
                state_d = ST_DIV;
              end
            end
          endcase
        end
      end

      ST_MUL, ST_DIV: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + ITER_CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          cnt_d    = '0;
          result_d = step_lo;
          // Multiply overflows when any bit lands in the upper half; the
          // divide remainder left in hi is simply discarded.
          ov_d     = (state_q == ST_MUL) ? |step_hi : 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      ov_q     <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu16_seq_unit.sv
// tb_alu16_seq_unit
// Drives directed and random operations into alu16_seq_unit and compares
// latency, result and flag against an arithmetic reference model.
module tb_alu16_seq_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ov;

  int total;
  int bad;

  alu16_seq_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ov        (ov)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition
  function automatic void refModel(input logic [15:0] ra, input logic [15:0] rb,
                                   input logic [1:0] rsel,
                                   output logic [15:0] res, output logic rov,
                                   output int lat);
    int unsigned sum;
    int          sres;
    longint      prod;
    res = '0;
    rov = 1'b0;
    lat = 1;
    case (rsel)
      2'd0: begin
        sum = int'(ra) + int'(rb);
        res = 16'(sum % 65536);
        rov = (sum > 65535);
      end
      2'd1: begin
        sres = int'($signed(ra)) - int'($signed(rb));
        res  = 16'(sres);
        rov  = (sres > 32767) || (sres < -32768);
      end
      2'd2: begin
        prod = longint'(ra) * longint'(rb);
        res  = 16'(prod % 65536);
        rov  = (prod > 65535);
        lat  = 17;
      end
      default: begin
        if (rb == 16'd0) begin
          res = 16'hFFFF;
          rov = 1'b1;
        end else begin
          res = 16'(int'(ra) / int'(rb));
          rov = 1'b0;
          lat = 17;
        end
      end
    endcase
  endfunction

  // One full transaction: accept, latency measurement, optional backpressure
  // window (with an optional ignored in_valid pulse), then release.
  task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                               input logic [1:0] op_sel, input int hold,
                               input bit pulse);
    logic [15:0] exp_res;
    logic        exp_ov;
    int          exp_lat;
    int          lat;
    refModel(op_a, op_b, op_sel, exp_res, exp_ov, exp_lat);

    @(negedge clk);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    a         = op_a;
    b         = op_b;
    sel       = op_sel;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Operands are captured on the accept edge; scramble them afterwards
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    sel      = 2'($urandom);

    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("result", 32'(result), 32'(exp_res));
    checkOutput("ov", 32'(ov), 32'(exp_ov));
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 0) begin
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sel      = 2'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_result", 32'(result), 32'(exp_res));
      checkOutput("hold_ov", 32'(ov), 32'(exp_ov));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_result_held", 32'(result), 32'(exp_res));
    @(posedge clk);
    #1;
    checkOutput("nothing_queued", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  rs;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;
    out_ready = 1'b0;

    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_ov", 32'(ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Directed cases
    applyStimulus(16'd62000, 16'd12345, 2'd0, 0, 1'b0);
    applyStimulus(16'd1000,  16'd2000,  2'd0, 0, 1'b0);
    applyStimulus(16'h8008,  16'd10,    2'd1, 0, 1'b0);
    applyStimulus(16'd32760, 16'hFEE8,  2'd1, 0, 1'b0);
    applyStimulus(16'd100,   16'd30,    2'd1, 0, 1'b0);
    applyStimulus(16'd800,   16'd1000,  2'd2, 0, 1'b0);
    applyStimulus(16'd32768, 16'd2,     2'd2, 0, 1'b0);
    applyStimulus(16'd200,   16'd150,   2'd2, 0, 1'b0);
    applyStimulus(16'd5324,  16'd0,     2'd3, 0, 1'b0);
    applyStimulus(16'd5324,  16'd17,    2'd3, 0, 1'b0);
    applyStimulus(16'd3,     16'd500,   2'd3, 0, 1'b0);
    applyStimulus(16'hFFFF,  16'hFFFF,  2'd2, 0, 1'b0);
    applyStimulus(16'hFFFF,  16'd1,     2'd3, 0, 1'b0);

    // Backpressure with an ignored operation attempt in the DONE window
    applyStimulus(16'd200, 16'd150, 2'd2, 5, 1'b1);

    // Leave a non-zero result with ov=1 so the reset clearing is visible
    applyStimulus(16'd62000, 16'd12345, 2'd0, 0, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    a        = 16'd200;
    b        = 16'd150;
    sel      = 2'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_ov", 32'(ov), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd1, 16'd2, 2'd0, 0, 1'b0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb = 16'd0;
      else if (rs == 2'd3 && $urandom_range(0, 1) == 1) rb = rb % 16'd300;
      applyStimulus(ra, rb, rs, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
